arm_regfile_mp: RTL and testbench

Parametrised multi-port register file for the multicycle/pipelined ARM core, replacing the fixed 2-read/1-write register file used by the datapath. It provides NRD combinational read ports and two write ports: a result port and a base-writeback port for pre/post-indexed loads and stores. It supports optional same-cycle write-to-read bypass, PC substitution on the top register, and a per-register busy scoreboard that tracks outstanding multicycle results. It sits between the instruction decode/operand-select muxes and the ALU/memory source registers.

---
 rtl/arm_regfile_mp_if.sv | 31 +++
 rtl/arm_regfile_mp.sv | 79 +++++++
 tb/tb_arm_regfile_mp.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/arm_regfile_mp_if.sv
// rtl/arm_regfile_mp_if.sv - read/write/scoreboard bus of the multi-port ARM register file
interface arm_regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int NRD   = 3
);
    logic [NRD*AW-1:0]    ra;
    logic [NRD*WIDTH-1:0] rd;
    logic [NRD-1:0]       rvalid;
    logic [WIDTH-1:0]     pc_in;
    logic                 we3;
    logic [AW-1:0]        wa3;
    logic [WIDTH-1:0]     wd3;
    logic                 we4;
    logic [AW-1:0]        wa4;
    logic [WIDTH-1:0]     wd4;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_addr;
    logic [NREGS-1:0]     busy;

    modport master (
        output ra, pc_in, we3, wa3, wd3, we4, wa4, wd4, alloc_en, alloc_addr,
        input  rd, rvalid, busy
    );

    modport slave (
        input  ra, pc_in, we3, wa3, wd3, we4, wa4, wd4, alloc_en, alloc_addr,
        output rd, rvalid, busy
    );
endinterface

// File: rtl/arm_regfile_mp.sv
// rtl/arm_regfile_mp.sv - multi-port register file with PC substitution, bypass and busy scoreboard
module arm_regfile_mp #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 16,
    parameter int AW     = 4,
    parameter int NRD    = 3,
    parameter int BYPASS = 1,
    parameter int PCOFF  = 8
) (
    input logic               clk,
    input logic               reset,
    arm_regfile_mp_if.slave   bus
);
    localparam logic [AW-1:0] PCA = AW'(NREGS - 1);

    // Only NREGS-1 entries are stored: the top index is the PC.
    logic [WIDTH-1:0]     regs [NREGS-1];
    logic [NREGS-1:0]     busy_q;
    logic [NREGS-1:0]     clr;
    logic [NREGS-1:0]     set;
    logic                 wr3;
    logic                 wr4;
    logic [NRD*WIDTH-1:0] rd_v;
    logic [NRD-1:0]       rv_v;
    logic [AW-1:0]        a;

    assign wr3 = bus.we3 && (bus.wa3 < PCA);
    assign wr4 = bus.we4 && (bus.wa4 < PCA);

    always_comb begin
        clr = '0;
        set = '0;
        if (wr3) clr[bus.wa3] = 1'b1;
        if (wr4) clr[bus.wa4] = 1'b1;
        if (bus.alloc_en && (bus.alloc_addr < PCA)) set[bus.alloc_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS - 1; i++) regs[i] <= '0;
            busy_q <= '0;
        end else begin
            // Port 3 is assigned last so it wins a same-address collision.
            if (wr4) regs[bus.wa4] <= bus.wd4;
            if (wr3) regs[bus.wa3] <= bus.wd3;
            // A fresh allocation beats the clear from a retiring producer.
            busy_q <= (busy_q & ~clr) | set;
        end
    end

    always_comb begin
        rd_v = '0;
        rv_v = '1;
        a    = '0;
        for (int i = 0; i < NRD; i++) begin
            a = bus.ra[i*AW +: AW];
            if (a == PCA) begin
                rd_v[i*WIDTH +: WIDTH] = bus.pc_in + WIDTH'(PCOFF);
            end else if (a < PCA) begin
                rd_v[i*WIDTH +: WIDTH] = regs[a];
                rv_v[i]                = ~busy_q[a];
                if ((BYPASS != 0) && reset) begin
                    if (wr4 && (bus.wa4 == a)) begin
                        rd_v[i*WIDTH +: WIDTH] = bus.wd4;
                        rv_v[i]                = 1'b1;
                    end
                    if (wr3 && (bus.wa3 == a)) begin
                        rd_v[i*WIDTH +: WIDTH] = bus.wd3;
                        rv_v[i]                = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.rd     = rd_v;
    assign bus.rvalid = rv_v;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_arm_regfile_mp.sv
// tb/tb_arm_regfile_mp.sv - directed and randomized bench for arm_regfile_mp (32b/16r bypass and 16b/8r no-bypass builds)
module tb_arm_regfile_mp;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_regfile_mp_if #(.WIDTH(32), .NREGS(16), .AW(4), .NRD(3)) bus_a ();
    arm_regfile_mp_if #(.WIDTH(16), .NREGS(8),  .AW(3), .NRD(4)) bus_b ();

    arm_regfile_mp #(.WIDTH(32), .NREGS(16), .AW(4), .NRD(3), .BYPASS(1), .PCOFF(8))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    arm_regfile_mp #(.WIDTH(16), .NREGS(8), .AW(3), .NRD(4), .BYPASS(0), .PCOFF(8))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic [31:0] ma_mem [15];
    logic [15:0] ma_busy;
    logic [15:0] mb_mem [7];
    logic [7:0]  mb_busy;
    int nchk = 0;
    int npass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) ma_mem[i] = '0;
        for (int i = 0; i < 7; i++) mb_mem[i] = '0;
        ma_busy = '0;
        mb_busy = '0;
    endtask

    task automatic model_edge();
        if (bus_a.we4 && bus_a.wa4 != 15) begin ma_mem[bus_a.wa4] = bus_a.wd4; ma_busy[bus_a.wa4] = 1'b0; end
        if (bus_a.we3 && bus_a.wa3 != 15) begin ma_mem[bus_a.wa3] = bus_a.wd3; ma_busy[bus_a.wa3] = 1'b0; end
        if (bus_a.alloc_en && bus_a.alloc_addr != 15) ma_busy[bus_a.alloc_addr] = 1'b1;
        if (bus_b.we4 && bus_b.wa4 != 7) begin mb_mem[bus_b.wa4] = bus_b.wd4; mb_busy[bus_b.wa4] = 1'b0; end
        if (bus_b.we3 && bus_b.wa3 != 7) begin mb_mem[bus_b.wa3] = bus_b.wd3; mb_busy[bus_b.wa3] = 1'b0; end
        if (bus_b.alloc_en && bus_b.alloc_addr != 7) mb_busy[bus_b.alloc_addr] = 1'b1;
    endtask

    function automatic logic [31:0] exp_rd_a(input int a);
        if (a == 15) return bus_a.pc_in + 32'd8;
        if (bus_a.we3 && bus_a.wa3 == a) return bus_a.wd3;
        if (bus_a.we4 && bus_a.wa4 == a) return bus_a.wd4;
        return ma_mem[a];
    endfunction

    function automatic logic exp_rv_a(input int a);
        if (a == 15) return 1'b1;
        if ((bus_a.we3 && bus_a.wa3 == a) || (bus_a.we4 && bus_a.wa4 == a)) return 1'b1;
        return !ma_busy[a];
    endfunction

    function automatic logic [15:0] exp_rd_b(input int a);
        logic [15:0] s;
        s = bus_b.pc_in + 16'd8;
        if (a == 7) return s;
        return mb_mem[a];
    endfunction

    function automatic logic exp_rv_b(input int a);
        if (a == 7) return 1'b1;
        return !mb_busy[a];
    endfunction

    task automatic check_all();
        int a;
        for (int p = 0; p < 3; p++) begin
            a = int'(bus_a.ra[p*4 +: 4]);
            chk($sformatf("a_rd%0d r%0d", p, a), bus_a.rd[p*32 +: 32], exp_rd_a(a));
            chk($sformatf("a_rvalid%0d r%0d", p, a), 32'(bus_a.rvalid[p]), 32'(exp_rv_a(a)));
        end
        chk("a_busy", 32'(bus_a.busy), 32'(ma_busy));
        for (int p = 0; p < 4; p++) begin
            a = int'(bus_b.ra[p*3 +: 3]);
            chk($sformatf("b_rd%0d r%0d", p, a), 32'(bus_b.rd[p*16 +: 16]), 32'(exp_rd_b(a)));
            chk($sformatf("b_rvalid%0d r%0d", p, a), 32'(bus_b.rvalid[p]), 32'(exp_rv_b(a)));
        end
        chk("b_busy", 32'(bus_b.busy), 32'(mb_busy));
    endtask

    task automatic idle();
        bus_a.we3 = 0; bus_a.we4 = 0; bus_a.alloc_en = 0;
        bus_a.wa3 = 0; bus_a.wa4 = 0; bus_a.wd3 = 0; bus_a.wd4 = 0; bus_a.alloc_addr = 0;
        bus_b.we3 = 0; bus_b.we4 = 0; bus_b.alloc_en = 0;
        bus_b.wa3 = 0; bus_b.wa4 = 0; bus_b.wd3 = 0; bus_b.wd4 = 0; bus_b.alloc_addr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        bus_a.ra = '0; bus_a.pc_in = '0;
        bus_b.ra = '0; bus_b.pc_in = '0;
        model_reset();
        #1;
        chk("rst_a_busy", 32'(bus_a.busy), 32'h0);
        chk("rst_a_rvalid", 32'(bus_a.rvalid), 32'h7);
        chk("rst_b_rvalid", 32'(bus_b.rvalid), 32'hF);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // r3 write plus r9 allocation, then reset without a clock edge
        bus_a.we3 = 1; bus_a.wa3 = 3; bus_a.wd3 = 32'hDEADBEEF;
        bus_a.alloc_en = 1; bus_a.alloc_addr = 9;
        cyc(); idle();
        bus_a.ra[3:0] = 4'd3;
        #1;
        chk("wr_r3", bus_a.rd[31:0], 32'hDEADBEEF);
        chk("alloc_r9", 32'(bus_a.busy), 32'h0200);
        reset = 1'b0;
        #1;
        chk("async_rst_r3", bus_a.rd[31:0], 32'h0);
        chk("async_rst_busy", 32'(bus_a.busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // same-address conflict, then distinct addresses
        bus_a.we3 = 1; bus_a.wa3 = 5; bus_a.wd3 = 32'h11;
        bus_a.we4 = 1; bus_a.wa4 = 5; bus_a.wd4 = 32'h22;
        cyc(); idle();
        bus_a.ra[3:0] = 4'd5;
        #1 chk("conflict_r5", bus_a.rd[31:0], 32'h11);
        bus_a.we3 = 1; bus_a.wa3 = 5; bus_a.wd3 = 32'h33;
        bus_a.we4 = 1; bus_a.wa4 = 6; bus_a.wd4 = 32'h44;
        cyc(); idle();
        bus_a.ra[7:4] = 4'd6;
        #1;
        chk("dual_r5", bus_a.rd[31:0], 32'h33);
        chk("dual_r6", bus_a.rd[63:32], 32'h44);

        // PC read and ignored PC write
        bus_a.pc_in = 32'h100; bus_a.ra[3:0] = 4'd15;
        #1;
        chk("pc_rd", bus_a.rd[31:0], 32'h108);
        chk("pc_rvalid", 32'(bus_a.rvalid[0]), 32'h1);
        bus_a.we3 = 1; bus_a.wa3 = 15; bus_a.wd3 = 32'hFFFF;
        cyc(); idle();
        #1 chk("pc_wr_ignored", bus_a.rd[31:0], 32'h108);

        // bypass on A, no bypass on B
        bus_a.we3 = 1; bus_a.wa3 = 2; bus_a.wd3 = 32'hA5A5; bus_a.ra[7:4] = 4'd2;
        bus_b.we3 = 1; bus_b.wa3 = 2; bus_b.wd3 = 16'hBEEF; bus_b.ra[5:3] = 3'd2;
        #1;
        chk("bypass_a", bus_a.rd[63:32], 32'hA5A5);
        chk("nobypass_b_old", 32'(bus_b.rd[31:16]), 32'h0);
        cyc(); idle();
        #1 chk("nobypass_b_new", 32'(bus_b.rd[31:16]), 32'hBEEF);

        // scoreboard on r7
        bus_a.ra[3:0] = 4'd7;
        bus_a.alloc_en = 1; bus_a.alloc_addr = 7;
        #1 chk("alloc_same_cycle_rvalid", 32'(bus_a.rvalid[0]), 32'h1);
        cyc(); idle();
        #1;
        chk("busy7_set", 32'(bus_a.busy[7]), 32'h1);
        chk("busy7_rvalid", 32'(bus_a.rvalid[0]), 32'h0);
        bus_a.we4 = 1; bus_a.wa4 = 7; bus_a.wd4 = 32'h42;
        #1;
        chk("wb_bypass_rvalid", 32'(bus_a.rvalid[0]), 32'h1);
        chk("wb_bypass_rd", bus_a.rd[31:0], 32'h42);
        cyc(); idle();
        #1 chk("busy7_clear", 32'(bus_a.busy[7]), 32'h0);
        bus_a.alloc_en = 1; bus_a.alloc_addr = 7;
        bus_a.we3 = 1; bus_a.wa3 = 7; bus_a.wd3 = 32'h77;
        cyc(); idle();
        #1 chk("alloc_beats_clear", 32'(bus_a.busy[7]), 32'h1);

        // B: independent reads on four ports and 16-bit PC wrap
        bus_b.we3 = 1; bus_b.wa3 = 1; bus_b.wd3 = 16'h1111;
        bus_b.we4 = 1; bus_b.wa4 = 4; bus_b.wd4 = 16'h4444;
        cyc();
        bus_b.we3 = 1; bus_b.wa3 = 3; bus_b.wd3 = 16'h3333;
        bus_b.we4 = 1; bus_b.wa4 = 6; bus_b.wd4 = 16'h6666;
        cyc(); idle();
        bus_b.ra = {3'd6, 3'd4, 3'd3, 3'd1};
        #1;
        chk("b_port0", 32'(bus_b.rd[15:0]),  32'h1111);
        chk("b_port1", 32'(bus_b.rd[31:16]), 32'h3333);
        chk("b_port2", 32'(bus_b.rd[47:32]), 32'h4444);
        chk("b_port3", 32'(bus_b.rd[63:48]), 32'h6666);
        bus_b.pc_in = 16'hFFFC; bus_b.ra[2:0] = 3'd7;
        #1 chk("b_pc_wrap", 32'(bus_b.rd[15:0]), 32'h0004);
        cyc();

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            bus_a.we3 = 1'($urandom_range(0, 1)); bus_a.wa3 = 4'($urandom_range(0, 15)); bus_a.wd3 = $urandom;
            bus_a.we4 = 1'($urandom_range(0, 1)); bus_a.wa4 = 4'($urandom_range(0, 15)); bus_a.wd4 = $urandom;
            bus_a.alloc_en = ($urandom_range(0, 2) == 0); bus_a.alloc_addr = 4'($urandom_range(0, 15));
            bus_a.pc_in = $urandom;
            for (int p = 0; p < 3; p++) bus_a.ra[p*4 +: 4] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) bus_a.ra[3:0] = bus_a.wa3;
            bus_b.we3 = 1'($urandom_range(0, 1)); bus_b.wa3 = 3'($urandom_range(0, 7)); bus_b.wd3 = 16'($urandom);
            bus_b.we4 = 1'($urandom_range(0, 1)); bus_b.wa4 = 3'($urandom_range(0, 7)); bus_b.wd4 = 16'($urandom);
            bus_b.alloc_en = ($urandom_range(0, 2) == 0); bus_b.alloc_addr = 3'($urandom_range(0, 7));
            bus_b.pc_in = 16'($urandom);
            for (int p = 0; p < 4; p++) bus_b.ra[p*3 +: 3] = 3'($urandom_range(0, 7));
            #1 check_all();
            cyc();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
